// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: requester drives start and
// operands; the subtractor returns busy, the done strobe and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one full-subtractor
// cell per clock with a registered borrow; done pulses WIDTH cycles after start.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res;
    logic [WIDTH-1:0] diff_q;
    logic             br, borrow_q, done_q;
    logic [CNT_W-1:0] cnt;
    logic             cell_d, cell_b;
    logic             last_bit;

    // Full subtractor: {difference, borrow-out} from minuend, subtrahend, borrow-in.
    function automatic logic [1:0] full_sub(input logic a0, input logic b0, input logic bin);
        logic d, bo;
        d  = a0 ^ b0 ^ bin;
        bo = (~a0 & b0) | (~(a0 ^ b0) & bin);
        return {d, bo};
    endfunction

    assign {cell_d, cell_b} = full_sub(sa[0], sb[0], br);
    assign last_bit         = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (bus.start) state_nxt = RUN;
        end else begin
            if (last_bit) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sa  <= bus.a;
                    sb  <= bus.b;
                    res <= '0;
                    br  <= 1'b0;
                    cnt <= '0;
                end
            end else begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                res <= {cell_d, res[WIDTH-1:1]};
                br  <= cell_b;
                cnt <= cnt + CNT_W'(1);
                // Final bit goes straight into the output register, so diff is whole on done.
                if (last_bit) begin
                    diff_q   <= {cell_d, res[WIDTH-1:1]};
                    borrow_q <= cell_b;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences,
// randomized ops against an arithmetic model, and an exhaustive 4-bit sweep.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done4_cnt = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) i8 ();
    serial_subtractor_if #(.WIDTH(4)) i4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    always @(negedge clk) if (i4.done === 1'b1) done4_cnt++;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One operation on the 8-bit unit; operands are scrambled during RUN.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic bo,
                       output int lat, output int busy_cnt, output logic tail);
        d = 'x; bo = 1'bx; lat = -1; busy_cnt = 0; tail = 1'bx;
        @(negedge clk);
        i8.start = 1'b1; i8.a = a; i8.b = b;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin i8.start = 1'b0; i8.a = ~a; i8.b = ~b; end
            if (i8.busy === 1'b1) busy_cnt++;
            if (i8.done === 1'b1) begin
                lat = i - 1; d = i8.diff; bo = i8.borrow_out;
                break;
            end
        end
        @(negedge clk);
        tail = i8.done;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] d, output logic bo, output int lat);
        d = 'x; bo = 1'bx; lat = -1;
        @(negedge clk);
        i4.start = 1'b1; i4.a = a; i4.b = b;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) i4.start = 1'b0;
            if (i4.done === 1'b1) begin
                lat = i - 1; d = i4.diff; bo = i4.borrow_out;
                break;
            end
        end
    endtask

    task automatic wait_idle8();
        int n;
        n = 0;
        while ((i8.busy !== 1'b0 || i8.done !== 1'b0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle8", 32'(n < 30), 32'd1);
    endtask

    initial begin
        logic [7:0] d8, ra, rb;
        logic [3:0] d4;
        logic [8:0] m9;
        logic [4:0] m5;
        logic       bo, tail;
        int         lat, bcnt, ndone, prev, hold_bad;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[7] = '{8'h01, 8'hFF, 8'h02, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst_n = 1'b0;
        i8.start = 1'b0; i8.a = '0; i8.b = '0;
        i4.start = 1'b0; i4.a = '0; i4.b = '0;
        #1;
        check("rst_busy", 32'(i8.busy), 32'd0);
        check("rst_done", 32'(i8.done), 32'd0);
        check("rst_diff", 32'(i8.diff), 32'd0);
        check("rst_borrow", 32'(i8.borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int k = 0; k < 9; k++) begin
            op8(vecs[k].a, vecs[k].b, d8, bo, lat, bcnt, tail);
            check($sformatf("vec%0d_diff", k), 32'(d8), 32'(vecs[k].d));
            check($sformatf("vec%0d_borrow", k), 32'(bo), 32'(vecs[k].bo));
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", k), 32'(bcnt), 32'd8);
            check($sformatf("vec%0d_done_one_cycle", k), 32'(tail), 32'd0);
        end

        // Start while busy is ignored
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'h80; i8.b = 8'h01;
        ndone = 0; prev = -1; d8 = '0; bo = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) i8.start = 1'b0;
            if (i == 3) begin i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF; end
            if (i == 4) i8.start = 1'b0;
            if (i8.done === 1'b1) begin ndone++; prev = i - 1; d8 = i8.diff; bo = i8.borrow_out; end
        end
        check("busy_ignore_ndone", 32'(ndone), 32'd1);
        check("busy_ignore_latency", 32'(prev), 32'd8);
        check("busy_ignore_diff", 32'(d8), 32'h7F);
        check("busy_ignore_borrow", 32'(bo), 32'd0);
        check("busy_ignore_idle", 32'(i8.busy), 32'd0);

        // Start held high: back-to-back operations every WIDTH+1 cycles
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'hAA; i8.b = 8'h55;
        ndone = 0; prev = -1; hold_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i8.done === 1'b1) begin
                if (prev >= 0) check("b2b_interval", 32'(i - prev), 32'd9);
                else check("b2b_first_latency", 32'(i - 1), 32'd8);
                prev = i;
                ndone++;
                check("b2b_borrow", 32'(i8.borrow_out), 32'd0);
            end
            if (prev >= 0 && i8.diff !== 8'h55) hold_bad++;
        end
        i8.start = 1'b0;
        check("b2b_ndone", 32'(ndone), 32'd4);
        check("b2b_diff_hold", 32'(hold_bad), 32'd0);
        wait_idle8();

        // Asynchronous reset mid-operation
        @(negedge clk);
        i8.start = 1'b1; i8.a = 8'h10; i8.b = 8'h20;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(i8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(i8.busy), 32'd0);
        check("abort_done", 32'(i8.done), 32'd0);
        check("abort_diff", 32'(i8.diff), 32'd0);
        check("abort_borrow", 32'(i8.borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i8.done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        op8(8'h10, 8'h20, d8, bo, lat, bcnt, tail);
        check("post_abort_diff", 32'(d8), 32'hF0);
        check("post_abort_borrow", 32'(bo), 32'd1);
        check("post_abort_latency", 32'(lat), 32'd8);

        // Randomized ops against arithmetic reference
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            m9 = {1'b0, ra} - {1'b0, rb};
            op8(ra, rb, d8, bo, lat, bcnt, tail);
            check($sformatf("rand_%02h_%02h_diff", ra, rb), 32'(d8), 32'(m9[7:0]));
            check($sformatf("rand_%02h_%02h_borrow", ra, rb), 32'(bo), 32'(ra < rb));
            check($sformatf("rand_%02h_%02h_latency", ra, rb), 32'(lat), 32'd8);
        end

        // Exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                m5 = 5'(x) - 5'(y);
                op4(4'(x), 4'(y), d4, bo, lat);
                check($sformatf("w4_%0d_%0d", x, y), {23'd0, lat == 4, bo, 3'd0, d4},
                      {23'd0, 1'b1, m5[4], 3'd0, m5[3:0]});
            end
        end
        @(negedge clk);
        check("w4_done_count", 32'(done4_cnt), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
